// File: rtl/memory_arbiter_if.sv
// Bus bundle between the pipeline's fetch/data ports, the memory arbiter and the
// single-ported RAM. The master side is the environment; the slave side is the arbiter.
interface memory_arbiter_if #(
  parameter int WORD_W = 32
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              ihit;
  logic              dhit;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] dload;
  logic              err;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, dhit, iload, dload, err, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, err, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and data accesses.
// Data wins by default; a starvation counter forces a fetch grant, a timeout aborts hung accesses.
module memory_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  memory_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IFETCH = 2'd1;
  localparam logic [1:0] S_DATA   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int TC_W = $clog2(TIMEOUT + 1);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_MAX);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [SC_W-1:0]   r_starve_cnt;
  logic [TC_W-1:0]   r_tmo_cnt;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_store;
  logic              r_wr;

  logic w_dreq;
  logic w_grant_d;
  logic w_grant_i;
  logic w_busy;
  logic w_access;
  logic w_abort;

  // Arbitration and access-termination decode.
  always_comb begin
    w_dreq    = bus.dREN | bus.dWEN;
    w_grant_d = w_dreq && (!bus.iREN || (r_starve_cnt < SC_MAX));
    w_grant_i = !w_grant_d && bus.iREN;
    w_busy    = (r_state == S_IFETCH) || (r_state == S_DATA);
    w_access  = w_busy && (bus.ramstate == RAM_ACCESS);
    w_abort   = w_busy && !w_access &&
                ((bus.ramstate == RAM_ERROR) || (r_tmo_cnt == TC_LAST));
  end

  // RAM drive comes only from the grant latches so it is stable for the whole access.
  always_comb begin
    bus.ramREN   = w_busy && !r_wr;
    bus.ramWEN   = w_busy && r_wr;
    bus.ramaddr  = w_busy ? r_addr : '0;
    bus.ramstore = (w_busy && r_wr) ? r_store : '0;
    bus.ihit     = w_access && (r_state == S_IFETCH) && bus.iREN;
    bus.dhit     = w_access && (r_state == S_DATA) && w_dreq;
    bus.iload    = (w_access && (r_state == S_IFETCH)) ? bus.ramload : '0;
    bus.dload    = (w_access && (r_state == S_DATA) && !r_wr) ? bus.ramload : '0;
    bus.err      = w_abort;
  end

  // FSM, grant latches, starvation and timeout counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_addr       <= '0;
      r_store      <= '0;
      r_wr         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state   <= S_DATA;
            r_addr    <= bus.daddr;
            r_store   <= bus.dstore;
            r_wr      <= bus.dWEN;
            r_tmo_cnt <= '0;
            if (bus.iREN) begin
              r_starve_cnt <= (r_starve_cnt == SC_MAX) ? r_starve_cnt
                                                       : r_starve_cnt + SC_W'(1);
            end else begin
              r_starve_cnt <= '0;
            end
          end else if (w_grant_i) begin
            r_state      <= S_IFETCH;
            r_addr       <= bus.iaddr;
            r_store      <= '0;
            r_wr         <= 1'b0;
            r_tmo_cnt    <= '0;
            r_starve_cnt <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_IFETCH, S_DATA: begin
          if (w_access || w_abort) begin
            r_state <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TC_W'(1);
          end
        end
        // Bubble so a requester updating on the hit edge is never re-granted stale.
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: expected accesses go into a scoreboard queue when
// requests are driven and are popped when the arbiter reports a hit or an error.
module tb_memory_arbiter;

  localparam logic [1:0] K_I   = 2'd0;
  localparam logic [1:0] K_DR  = 2'd1;
  localparam logic [1:0] K_DW  = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   w;

  memory_arbiter_if #(.WORD_W(32)) bus ();

  memory_arbiter #(.WORD_W(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits up to budget falling edges for a hit/err and checks it against the scoreboard head.
  task automatic expect_event(input string tag, input int budget, output int waited);
    exp_t       e;
    logic [1:0] k;
    bit         seen;
    seen   = 1'b0;
    waited = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      waited = c + 1;
      if (bus.ihit || bus.dhit || bus.err) begin
        seen = 1'b1;
        chk({tag, "_onehot"}, 32'(int'(bus.ihit) + int'(bus.dhit) + int'(bus.err)), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          k = bus.err ? K_ERR : (bus.ihit ? K_I : (bus.ramWEN ? K_DW : K_DR));
          chk({tag, "_kind"}, 32'(k), 32'(e.kind));
          chk({tag, "_addr"}, bus.ramaddr, e.addr);
          case (e.kind)
            K_I: begin
              chk({tag, "_iload"}, bus.iload, e.data);
              chk({tag, "_ramREN"}, 32'(bus.ramREN), 32'd1);
            end
            K_DR: begin
              chk({tag, "_dload"}, bus.dload, e.data);
              chk({tag, "_ramREN"}, 32'(bus.ramREN), 32'd1);
            end
            K_DW: begin
              chk({tag, "_ramstore"}, bus.ramstore, e.data);
              chk({tag, "_ramWEN"}, 32'(bus.ramWEN), 32'd1);
              chk({tag, "_ramREN"}, 32'(bus.ramREN), 32'd0);
              chk({tag, "_dload"}, bus.dload, 32'd0);
            end
            default: begin
              chk({tag, "_loads"}, bus.iload | bus.dload, 32'd0);
            end
          endcase
        end
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'(seen), 32'd1);
  endtask

  // DONE bubble: enables low and no handshakes, then step into IDLE.
  task automatic check_done(input string tag);
    @(negedge clk);
    chk({tag, "_done_en"}, 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    chk({tag, "_done_hit"}, 32'({bus.ihit, bus.dhit, bus.err}), 32'd0);
    tick();
  endtask

  // iREN held, dREN re-presented each IDLE: expected grant order D,D,D,D,I,D.
  task automatic starve_seq(input string tag);
    int wt;
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h0000_0200;
    for (int k = 0; k < 6; k++) begin
      bus.dREN    = 1'b1;
      bus.daddr   = 32'h0000_0300 + 32'(k * 4);
      bus.ramload = 32'hA000_0000 + 32'(k);
      if (k == 4) push(K_I, 32'h0000_0200, bus.ramload);
      else        push(K_DR, bus.daddr, bus.ramload);
      expect_event($sformatf("%s%0d", tag, k), 2, wt);
      tick();
      if (k != 4) bus.dREN = 1'b0;
      check_done($sformatf("%s%0d", tag, k));
    end
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.iREN     = 1'b0;
    bus.iaddr    = 32'd0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'd0;
    bus.dstore   = 32'd0;
    bus.ramload  = 32'd0;
    bus.ramstate = 2'd0;

    @(negedge clk);
    chk("reset_en", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    chk("reset_hit", 32'({bus.ihit, bus.dhit, bus.err}), 32'd0);
    chk("reset_addr", bus.ramaddr, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single fetch with immediate ACCESS.
    bus.ramstate = 2'd2;
    bus.ramload  = 32'h1234_5678;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h0000_0040;
    push(K_I, 32'h0000_0040, 32'h1234_5678);
    expect_event("fetch", 2, w);
    tick();
    bus.iREN = 1'b0;
    check_done("fetch");

    // Simultaneous fetch and store: data first, fetch after the bubble.
    bus.ramload = 32'h1111_2222;
    bus.iREN    = 1'b1;
    bus.iaddr   = 32'h0000_0080;
    bus.dWEN    = 1'b1;
    bus.daddr   = 32'h0000_0100;
    bus.dstore  = 32'hDEAD_BEEF;
    push(K_DW, 32'h0000_0100, 32'hDEAD_BEEF);
    push(K_I, 32'h0000_0080, 32'h1111_2222);
    expect_event("both_d", 2, w);
    tick();
    bus.dWEN = 1'b0;
    check_done("both_d");
    expect_event("both_i", 2, w);
    tick();
    bus.iREN = 1'b0;
    check_done("both_i");

    starve_seq("starve");

    // RAM stuck BUSY: abort on the eighth DATA cycle.
    bus.ramstate = 2'd1;
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h0000_0500;
    push(K_ERR, 32'h0000_0500, 32'd0);
    expect_event("tmo", 12, w);
    chk("tmo_cycles", 32'(w), 32'd9);
    tick();
    bus.dREN = 1'b0;
    check_done("tmo");

    // RAM ERROR on a fetch, retry completes.
    bus.ramstate = 2'd3;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h0000_0600;
    push(K_ERR, 32'h0000_0600, 32'd0);
    expect_event("rerr", 2, w);
    tick();
    bus.ramstate = 2'd2;
    bus.ramload  = 32'hCAFE_0001;
    push(K_I, 32'h0000_0600, 32'hCAFE_0001);
    check_done("rerr");
    expect_event("retry", 2, w);
    tick();
    bus.iREN = 1'b0;
    check_done("retry");

    // dREN and dWEN together behave as a write.
    bus.ramload = 32'hFFFF_FFFF;
    bus.dREN    = 1'b1;
    bus.dWEN    = 1'b1;
    bus.daddr   = 32'h0000_0700;
    bus.dstore  = 32'h55AA_55AA;
    push(K_DW, 32'h0000_0700, 32'h55AA_55AA);
    expect_event("rw", 2, w);
    tick();
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    check_done("rw");

    // Async reset in the middle of a write.
    bus.ramstate = 2'd1;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h0000_0900;
    bus.dWEN     = 1'b1;
    bus.daddr    = 32'h0000_0800;
    bus.dstore   = 32'h0000_0001;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_wen", 32'(bus.ramWEN), 32'd1);
    bus.ramstate = 2'd2;
    #1;
    chk("rst_pre_dhit", 32'(bus.dhit), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wen", 32'(bus.ramWEN), 32'd0);
    chk("rst_dhit", 32'(bus.dhit), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_addr", bus.ramaddr, 32'd0);
    tick();
    rst      = 1'b0;
    bus.dWEN = 1'b0;
    starve_seq("post_rst");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
